// File: rtl/regfile_multiport.sv
// Multi-port integer register file for the RV32 core.
// Registered reads with write bypass, plus a one-entry-per-cycle clear engine.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP-1:0]      rd_en,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                clr_req,
  output logic                busy,
  output logic                clr_done
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW:0] NR   = (AW+1)'(NREGS);
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     idx_q, idx_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] mem [NREGS];

  logic wr_ok;
  logic wr_commit;
  logic clr_act;

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign clr_done  = done_q;
  assign clr_act   = (state_q == CLEAR);

  assign wr_ok     = ({1'b0, wr_addr} < NR) &&
                     !((ZERO_REG != 0) && (wr_addr == '0));
  assign wr_commit = wr_valid && wr_ready && wr_ok;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + (AW+1)'(1);
        if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Clear and write never coincide: wr_ready is low in CLEAR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (clr_act) begin
      mem[idx_q[IW-1:0]] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  for (genvar g = 0; g < NRP; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            ra_ok;
    logic [XLEN-1:0] rv;
    logic [XLEN-1:0] rd_q;

    assign ra    = rs_addr[g*AW +: AW];
    assign ra_ok = ({1'b0, ra} < NR) &&
                   !((ZERO_REG != 0) && (ra == '0));

    always_comb begin
      rv = '0;
      unique case (1'b1)
        !ra_ok:
          rv = '0;
        (BYPASS != 0) && wr_commit && (wr_addr == ra):
          rv = wr_data;
        default:
          rv = mem[ra[IW-1:0]];
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if (rd_en[g]) begin
        rd_q <= rv;
      end
    end

    assign rs_data[g*XLEN +: XLEN] = rd_q;
  end

endmodule
